module_digit_loader: RTL and testbench

MODULE_DIGIT_LOADER -- requirements
Module: module_digit_loader

---
 rtl/fsmload_pkg.sv | 13 +
 rtl/module_timeout_cnt.sv | 39 +++
 rtl/module_digit_loader.sv | 108 ++++++++++
 tb/tb_module_digit_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsmload_pkg.sv
// Shared types and defaults for the keypad digit loader.
// Imported by the loader top and its idle timer.
package fsmload_pkg;

  localparam int NUM_DIGITS_DEF     = 3;
  localparam int TIMEOUT_CYCLES_DEF = 0;

  typedef enum logic {
    ST_COLLECT,
    ST_COMMIT
  } state_t;

endpackage

// File: rtl/module_timeout_cnt.sv
// Idle timer: expire rises on the last of TIMEOUT_CYCLES
// consecutive enabled cycles without a restart.
module module_timeout_cnt
  import fsmload_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic expire
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_in;
    assign unused_in = ^{clk, rst, restart, enable};
    assign expire    = 1'b0;
  end else begin : g_on
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign expire = enable && (cnt == LAST);

    // count idle cycles, cleared by key, disable or expiry
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
      end else if (restart || !enable || expire) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/module_digit_loader.sv
// Keypad entry sequencer: steers digit strobes into
// per-digit load/clear pulses and signals entry completion.
module module_digit_loader
  import fsmload_pkg::*;
#(
  parameter int NUM_DIGITS     = NUM_DIGITS_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              tecla,
  input  logic                              borrar,
  input  logic                              enter,
  output logic [NUM_DIGITS-1:0]             load,
  output logic [NUM_DIGITS-1:0]             clr_digit,
  output logic                              load_out,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_cnt,
  output logic                              timeout
);

  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

  state_t                state, state_d;
  logic [CW-1:0]         cnt_d;
  logic [NUM_DIGITS-1:0] load_d;
  logic [NUM_DIGITS-1:0] clr_d;
  logic                  lo_d;
  logic                  to_d;
  logic                  restart;
  logic                  enable;
  logic                  expire;
  logic                  held;

  assign held   = (digit_cnt != '0);
  assign enable = (state == ST_COLLECT) && held;

  module_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .enable (enable),
    .expire (expire)
  );

  // key priority tecla > enter > borrar, then idle expiry
  always_comb begin
    state_d = state;
    cnt_d   = digit_cnt;
    load_d  = '0;
    clr_d   = '0;
    lo_d    = 1'b0;
    to_d    = 1'b0;
    restart = 1'b0;
    unique case (state)
      ST_COMMIT: begin
        lo_d    = 1'b1;
        cnt_d   = '0;
        state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (tecla) begin
          load_d  = ONE << digit_cnt;
          cnt_d   = digit_cnt + CW'(1);
          restart = 1'b1;
          if (cnt_d == FULL) state_d = ST_COMMIT;
        end else if (enter && held) begin
          restart = 1'b1;
          state_d = ST_COMMIT;
        end else if (borrar && held) begin
          cnt_d   = digit_cnt - CW'(1);
          clr_d   = ONE << cnt_d;
          restart = 1'b1;
        end else if (expire) begin
          to_d  = 1'b1;
          cnt_d = '0;
          for (int i = 0; i < NUM_DIGITS; i++) begin
            clr_d[i] = (CW'(i) < digit_cnt);
          end
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // state and registered output pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_COLLECT;
      digit_cnt <= '0;
      load      <= '0;
      clr_digit <= '0;
      load_out  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_d;
      digit_cnt <= cnt_d;
      load      <= load_d;
      clr_digit <= clr_d;
      load_out  <= lo_d;
      timeout   <= to_d;
    end
  end

endmodule

// File: tb/tb_module_digit_loader.sv
// Scoreboard bench for the digit loader: a 3-digit
// instance with timeout and an 8-digit one without.
module tb_module_digit_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tecla = 1'b0;
  logic borrar = 1'b0;
  logic enter = 1'b0;

  logic [2:0] load3, clr3;
  logic       lo3, to3;
  logic [1:0] cnt3;
  logic [7:0] load8, clr8;
  logic       lo8, to8;
  logic [3:0] cnt8;

  module_digit_loader #(
    .NUM_DIGITS(3),
    .TIMEOUT_CYCLES(50)
  ) dut3 (
    .clk(clk), .rst(rst), .tecla(tecla),
    .borrar(borrar), .enter(enter),
    .load(load3), .clr_digit(clr3),
    .load_out(lo3), .digit_cnt(cnt3),
    .timeout(to3)
  );

  module_digit_loader #(
    .NUM_DIGITS(8),
    .TIMEOUT_CYCLES(0)
  ) dut8 (
    .clk(clk), .rst(rst), .tecla(tecla),
    .borrar(borrar), .enter(enter),
    .load(load8), .clr_digit(clr8),
    .load_out(lo8), .digit_cnt(cnt8),
    .timeout(to8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [7:0] load;
    logic [7:0] clr;
    logic       lo;
    logic       to;
    logic [3:0] cnt;
  } exp_t;

  exp_t q3[$];
  exp_t q8[$];
  int   passed = 0;
  int   total  = 0;

  int   np[2] = '{3, 8};
  int   tp[2] = '{50, 0};
  int   m_cnt[2];
  int   m_idle[2];
  bit   m_commit[2];

  function automatic exp_t zero_exp(int due);
    exp_t x;
    x.due  = due;
    x.load = '0;
    x.clr  = '0;
    x.lo   = 1'b0;
    x.to   = 1'b0;
    x.cnt  = '0;
    return x;
  endfunction

  // entry-level behaviour: digits held, pending commit, idle age
  function automatic exp_t model_step(int k, bit t, bit e,
                                      bit b, int due);
    exp_t x = zero_exp(due);
    if (m_commit[k]) begin
      x.lo = 1'b1;
      m_cnt[k] = 0;
      m_commit[k] = 1'b0;
      m_idle[k] = 0;
    end else if (t) begin
      x.load[m_cnt[k]] = 1'b1;
      m_cnt[k] = m_cnt[k] + 1;
      m_idle[k] = 0;
      if (m_cnt[k] == np[k]) m_commit[k] = 1'b1;
    end else if (e && m_cnt[k] > 0) begin
      m_commit[k] = 1'b1;
      m_idle[k] = 0;
    end else if (b && m_cnt[k] > 0) begin
      m_cnt[k] = m_cnt[k] - 1;
      x.clr[m_cnt[k]] = 1'b1;
      m_idle[k] = 0;
    end else if (tp[k] > 0 && m_cnt[k] > 0) begin
      m_idle[k] = m_idle[k] + 1;
      if (m_idle[k] == tp[k]) begin
        x.to = 1'b1;
        x.clr = 8'((1 << m_cnt[k]) - 1);
        m_cnt[k] = 0;
        m_idle[k] = 0;
      end
    end else begin
      m_idle[k] = 0;
    end
    x.cnt = 4'(m_cnt[k]);
    return x;
  endfunction

  task automatic tick(bit t, bit e, bit b);
    @(posedge clk);
    #1;
    tecla  = t;
    enter  = e;
    borrar = b;
    q3.push_back(model_step(0, t, e, b, cyc + 1));
    q8.push_back(model_step(1, t, e, b, cyc + 1));
  endtask

  task automatic idle(int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(int n);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tecla = 1'b0;
    enter = 1'b0;
    borrar = 1'b0;
    q3.delete();
    q8.delete();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_idle[k] = 0;
      m_commit[k] = 1'b0;
    end
    q3.push_back(zero_exp(cyc));
    q8.push_back(zero_exp(cyc));
    repeat (n) begin
      @(posedge clk);
      #1;
      q3.push_back(zero_exp(cyc));
      q8.push_back(zero_exp(cyc));
    end
    rst = 1'b1;
  endtask

  task automatic check(string nm, exp_t x, logic [7:0] ld,
                       logic [7:0] cl, logic lo, logic to,
                       logic [3:0] cn);
    total++;
    if (ld === x.load && cl === x.clr && lo === x.lo &&
        to === x.to && cn === x.cnt) begin
      passed++;
    end else begin
      $display("FAIL %s cyc=%0d got ld=%h clr=%h lo=%b to=%b cnt=%0d exp ld=%h clr=%h lo=%b to=%b cnt=%0d",
               nm, cyc, ld, cl, lo, to, cn,
               x.load, x.clr, x.lo, x.to, x.cnt);
    end
  endtask

  task automatic check_inv(string nm, logic [7:0] ld,
                           logic [7:0] cl, logic lo, logic to);
    total++;
    if (!(lo && to) && $onehot0(ld) &&
        ($onehot0(cl) || to)) begin
      passed++;
    end else begin
      $display("FAIL %s cyc=%0d ld=%h clr=%h lo=%b to=%b",
               nm, cyc, ld, cl, lo, to);
    end
  endtask

  // monitor: pop expectations due this cycle and compare
  always @(negedge clk) begin
    exp_t x;
    while (q3.size() > 0 && q3[0].due <= cyc) begin
      x = q3.pop_front();
      if (x.due < cyc) begin
        total++;
        $display("FAIL stale3 cyc=%0d due=%0d", cyc, x.due);
      end else begin
        check("dut3", x, {5'b0, load3}, {5'b0, clr3},
              lo3, to3, {2'b0, cnt3});
      end
    end
    while (q8.size() > 0 && q8[0].due <= cyc) begin
      x = q8.pop_front();
      if (x.due < cyc) begin
        total++;
        $display("FAIL stale8 cyc=%0d due=%0d", cyc, x.due);
      end else begin
        check("dut8", x, load8, clr8, lo8, to8, cnt8);
      end
    end
    if (rst) begin
      check_inv("inv3", {5'b0, load3}, {5'b0, clr3}, lo3, to3);
      check_inv("inv8", load8, clr8, lo8, to8);
    end
  end

  initial begin
    int p;
    do_reset(3);
    idle(5);
    // three digits ten cycles apart
    repeat (3) begin
      tick(1'b1, 1'b0, 1'b0);
      idle(9);
    end
    idle(5);
    // two digits, backspace, digit, enter
    tick(1'b1, 1'b0, 1'b0); idle(9);
    tick(1'b1, 1'b0, 1'b0); idle(4);
    tick(1'b0, 1'b0, 1'b1); idle(4);
    tick(1'b1, 1'b0, 1'b0); idle(9);
    tick(1'b0, 1'b1, 1'b0); idle(9);
    // coincident strobes with one digit held
    tick(1'b1, 1'b0, 1'b0); idle(9);
    tick(1'b1, 1'b1, 1'b1); idle(4);
    tick(1'b0, 1'b1, 1'b0); idle(5);
    // idle timeout on a single digit
    tick(1'b1, 1'b0, 1'b0); idle(60);
    tick(1'b0, 1'b1, 1'b0); idle(5);
    // reset mid entry
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    do_reset(1);
    tick(1'b1, 1'b0, 1'b0); idle(5);
    tick(1'b0, 1'b1, 1'b0); idle(5);
    // back-to-back digits incl. one in the commit cycle
    repeat (9) tick(1'b1, 1'b0, 1'b0);
    idle(5);
    // randomized phases with varying key density
    for (int ph = 0; ph < 15; ph++) begin
      p = (ph % 3 == 0) ? 2 : ((ph % 3 == 1) ? 10 : 35);
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(999) == 0) begin
          do_reset(1);
        end else begin
          tick($urandom_range(99) < p,
               $urandom_range(99) < p / 2,
               $urandom_range(99) < p);
        end
      end
    end
    idle(5);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (q3.size() == 0 && q8.size() == 0) begin
      passed++;
    end else begin
      $display("FAIL drain q3=%0d q8=%0d required 0",
               q3.size(), q8.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
